// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: accepts an operand pair, emits one carry-flush bit,
// then streams both operands LSB-first with framing strobes to a bit-serial adder.
module serial_operand_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             bit_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, FLUSH, SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CW-1:0]    r_cnt;
    logic             r_a;
    logic             r_b;
    logic             r_bit_valid;
    logic             r_bit_last;
    logic             r_busy;
    logic             w_last;
    logic             w_hs;

    assign w_last    = (r_state == SHIFT) && (r_cnt == LAST);
    assign in_ready  = aresetn && ((r_state == IDLE) || w_last);
    assign w_hs      = in_valid && in_ready;
    assign a         = r_a;
    assign b         = r_b;
    assign bit_valid = r_bit_valid;
    assign bit_last  = r_bit_last;
    assign busy      = r_busy;

    // Outputs are registered, so each branch loads the values for the state being entered.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_sa        <= '0;
            r_sb        <= '0;
            r_cnt       <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_sa    <= in_a;
                        r_sb    <= in_b;
                        r_state <= FLUSH;
                        r_busy  <= 1'b1;
                    end
                end
                FLUSH: begin
                    r_state     <= SHIFT;
                    r_cnt       <= '0;
                    r_a         <= r_sa[0];
                    r_b         <= r_sb[0];
                    r_bit_valid <= 1'b1;
                    r_bit_last  <= 1'b0;
                end
                SHIFT: begin
                    if (r_cnt != LAST) begin
                        r_sa       <= r_sa >> 1;
                        r_sb       <= r_sb >> 1;
                        r_a        <= r_sa[1];
                        r_b        <= r_sb[1];
                        r_cnt      <= r_cnt + ONE;
                        r_bit_last <= (r_cnt + ONE) == LAST;
                    end else begin
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_bit_valid <= 1'b0;
                        r_bit_last  <= 1'b0;
                        r_cnt       <= '0;
                        if (w_hs) begin
                            r_sa    <= in_a;
                            r_sb    <= in_b;
                            r_state <= FLUSH;
                        end else begin
                            r_sa    <= r_sa >> 1;
                            r_sb    <= r_sb >> 1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb_serial_operand_feeder: random and directed operand pairs checked against a
// queue-of-frames schedule model and an attached behavioural serial adder.
module tb_serial_operand_feeder;
    localparam int W = 4;

    typedef struct packed {
        logic a;
        logic b;
        logic bv;
        logic bl;
    } frame_t;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready;
    logic         a;
    logic         b;
    logic         bit_valid;
    logic         bit_last;
    logic         busy;

    serial_operand_feeder #(.WIDTH(W)) dut (
        .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .a(a), .b(b),
        .bit_valid(bit_valid), .bit_last(bit_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected output frames, front = frame on the outputs this cycle.
    frame_t       exp_q[$];
    logic [W-1:0] sum_q[$];
    logic         m_hs;

    function automatic logic model_ready();
        return aresetn && (exp_q.size() <= 1);
    endfunction

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            exp_q.delete();
            sum_q.delete();
        end else begin
            cyc++;
            m_hs = in_valid && (exp_q.size() <= 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_hs) begin
                exp_q.push_back('0);
                for (int i = 0; i < W; i++)
                    exp_q.push_back({in_a[i], in_b[i], 1'b1, i == W - 1});
                sum_q.push_back(in_a + in_b);
            end
        end
    end

    // Downstream bit-serial adder: q = a^b^c, carry registered.
    logic c = 1'b0;
    logic q;
    assign q = a ^ b ^ c;
    always @(posedge clk) c <= (a & b) | (a & c) | (b & c);

    frame_t       f;
    int           bidx = 0;
    int           nflush = 0;
    logic [W-1:0] q_acc, a_acc, b_acc;
    logic [W-1:0] last_q = '0, last_a = '0, last_b = '0;

    always @(negedge clk) begin
        f = (exp_q.size() > 0) ? exp_q[0] : frame_t'(0);
        check("a", a, f.a);
        check("b", b, f.b);
        check("bit_valid", bit_valid, f.bv);
        check("bit_last", bit_last, f.bl);
        check("busy", busy, exp_q.size() != 0);
        check("in_ready", in_ready, model_ready());
        if (!aresetn) begin
            bidx = 0;
            nflush = 0;
        end else if (bit_valid === 1'b1) begin
            if (bidx == 0) check("one_flush", nflush, 1);
            nflush = 0;
            q_acc[bidx] = q;
            a_acc[bidx] = a;
            b_acc[bidx] = b;
            bidx++;
            if (bit_last === 1'b1 || bidx >= W) begin
                if (sum_q.size() > 0) check("sum", q_acc, sum_q.pop_front());
                last_q = q_acc;
                last_a = a_acc;
                last_b = b_acc;
                bidx = 0;
            end
        end else if (busy === 1'b1) begin
            nflush++;
        end
    end

    // Offer a pair until accepted; with bp set, operands change every refused cycle.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input bit bp,
                        output logic [W-1:0] got_a, output logic [W-1:0] got_b, output int acc_cyc);
        logic ok;
        int n = 0;
        in_valid = 1'b1;
        in_a = va;
        in_b = vb;
        forever begin
            ok = in_ready;
            got_a = in_a;
            got_b = in_b;
            @(posedge clk);
            if (ok) break;
            n++;
            if (n > 100) begin
                check("send_timeout", n, 0);
                break;
            end
            #1;
            if (bp) begin
                in_a = W'($urandom);
                in_b = W'($urandom);
            end
        end
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0;
        in_a = W'($urandom);
        in_b = W'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < 100, 1);
        #1;
    endtask

    logic [W-1:0] ga, gb, ga2, gb2;
    int           c1, c2;

    initial begin
        in_valid = 1'b1;
        in_a = 4'hA;
        in_b = 4'h5;
        repeat (3) @(negedge clk);
        #1;
        check("reset_no_busy", busy, 0);
        in_valid = 1'b0;
        aresetn = 1'b1;

        send(4'b0101, 4'b0011, 1'b0, ga, gb, c1);
        wait_idle();
        check("single_a", last_a, 4'b0101);
        check("single_b", last_b, 4'b0011);
        check("single_q", last_q, 4'b1000);

        send(4'hF, 4'h1, 1'b0, ga, gb, c1);
        send(4'h0, 4'h0, 1'b0, ga, gb, c2);
        wait_idle();
        check("b2b_gap", c2 - c1, W + 1);
        check("carry_iso_q", last_q, 4'h0);

        send(4'h2, 4'h7, 1'b0, ga, gb, c1);
        send(4'h9, 4'h6, 1'b1, ga2, gb2, c2);
        wait_idle();
        check("bp_gap", c2 - c1, W + 1);
        check("bp_capture_a", last_a, ga2);
        check("bp_capture_b", last_b, gb2);

        send(4'h5, 4'h6, 1'b0, ga, gb, c1);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_reset_bit_valid", bit_valid, 1);
        aresetn = 1'b0;
        #1;
        check("async_a", a, 0);
        check("async_b", b, 0);
        check("async_bit_valid", bit_valid, 0);
        check("async_busy", busy, 0);
        check("async_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        aresetn = 1'b1;
        send(4'h3, 4'h4, 1'b0, ga, gb, c1);
        wait_idle();
        check("post_reset_a", last_a, 4'b0011);
        check("post_reset_b", last_b, 4'b0100);
        check("post_reset_q", last_q, 4'b0111);

        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ga, gb, c1);
        end
        wait_idle();
        check("sum_queue_drained", sum_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_operand_feeder.md
# serial_operand_feeder

Upstream stage for the bit-serial adder (inputs `a`, `b`; outputs `q`, `state` = carry). It accepts two WIDTH-bit operands through a valid/ready handshake. It first emits one flush bit with `a`=`b`=0, which forces the adder's carry to 0 because majority(0,0,c)=0. It then shifts both operands out LSB-first, one bit per clock, with framing strobes, so the downstream adder produces `q` = in_a+in_b (mod 2^WIDTH) on the WIDTH strobed cycles.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- aresetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  feeder can accept an operand pair this cycle.
- in_a  in  WIDTH  operand A, sampled only on handshake.
- in_b  in  WIDTH  operand B, sampled only on handshake.
- a  out  1  serial bit of A to the adder; registered.
- b  out  1  serial bit of B to the adder; registered.
- bit_valid  out  1  `a`/`b` carry a data bit this cycle (low during flush/idle); registered.
- bit_last  out  1  this cycle carries bit WIDTH-1; registered.
- busy  out  1  flush or shift in progress; registered.

## Operation
- State machine has three states: IDLE, FLUSH, SHIFT. Storage: two WIDTH-bit shift registers `sa`/`sb` and a bit counter `cnt` of clog2(WIDTH) bits.
- Handshake occurs at a rising edge where in_valid=1 and in_ready=1. At that edge in_a/in_b are copied into `sa`/`sb`. The inputs may change freely afterwards.
- in_ready = (state==IDLE) OR (state==SHIFT AND cnt==WIDTH-1). It is combinational from state and cnt. It is forced to 0 while aresetn=0.
- IDLE:
  - a=b=0, bit_valid=0, bit_last=0, busy=0.
  - On handshake, go to FLUSH.
- FLUSH (exactly one cycle):
  - a=b=0, bit_valid=0, busy=1.
  - Go to SHIFT with cnt=0.
- SHIFT:
  - a=sa[0], b=sb[0], bit_valid=1, busy=1, bit_last=(cnt==WIDTH-1).
  - Each edge shifts `sa`/`sb` right by one (zero fill) and increments cnt.
  - At cnt==WIDTH-1, go to FLUSH if a handshake occurs on that edge, otherwise go to IDLE.
- Operand transfer is never dropped or repeated. in_valid held high while in_ready=0 causes no action.
- Throughput back-to-back is one operand pair per WIDTH+1 cycles.

## Timing
- Handshake at edge k:
  - Cycle after edge k: flush, a=b=0, bit_valid=0.
  - Cycles after edges k+1..k+WIDTH: bit i of A/B, for i=0..WIDTH-1.
  - bit_last is high only with bit WIDTH-1.
- Downstream adder `q` for bit i is valid in the same cycle as bit i. The carry after bit i appears on `state` one cycle later.
- All outputs except in_ready change only on rising clk or on aresetn assertion.
- Reset:
  - aresetn low immediately (asynchronously) forces state=IDLE, a=0, b=0, bit_valid=0, bit_last=0, busy=0, cnt=0, sa=sb=0.
  - Asserting reset mid-SHIFT abandons the operation; no further bits are emitted.
  - The first handshake is possible at the first rising edge after aresetn deasserts.
- Simultaneous events:
  - Handshake on the last SHIFT edge means bit WIDTH-1 of the old pair is emitted in that cycle, and the next cycle is the flush for the new pair.
  - No idle gap beyond the flush cycle.

## Test plan
- Reset: hold aresetn=0 for 3 cycles with in_valid=1 -> a=b=bit_valid=bit_last=busy=0 and in_ready=0 throughout; no operation starts.
- Single op, WIDTH=4, in_a=4'b0101, in_b=4'b0011 at edge k:
  - Cycle k+1: flush, a=b=0.
  - Cycles k+2..k+5: a=1,0,1,0 and b=1,1,0,0, bit_valid=1.
  - bit_last only in cycle k+5.
  - Attached adder q=0,0,0,1 (sum 8).
  - Cycle k+6: IDLE, busy=0.
- Carry isolation, WIDTH=4: 4'hF+4'h1, then back-to-back 4'h0+4'h0 accepted on the last-bit edge -> flush cycle follows immediately; adder q for the second op is 0,0,0,0 (carry cleared); in_ready was 1 on the last-bit cycle.
- Back-pressure: in_valid=1 with new operands during SHIFT cycles 0..2 -> in_ready=0, no capture; captured only at the cnt=3 edge; the operands are the values present at that edge.
- Mid-operation reset: aresetn pulsed low during bit 1 -> outputs go to 0 asynchronously; after release, a new op 4'h3+4'h4 gives a flush then a=1,1,0,0 and b=0,0,1,0, adder q=1,1,1,0.
- Randomised: 200 random operand pairs with random in_valid gaps -> per-op sum collected from adder q on bit_valid cycles equals (in_a+in_b) mod 2^WIDTH; every op is preceded by exactly one flush cycle.
